// File: rtl/rsa_cipher.sv
// RSA modular exponentiation engine: msg^exp mod N using constant-time right-to-left
// square-and-multiply built on a bit-serial interleaved modular multiplier.
module rsa_cipher #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [WORD_WIDTH-1:0] msg_in,
    input  logic [WORD_WIDTH-1:0] N,
    input  logic [WORD_WIDTH-1:0] e,
    input  logic [WORD_WIDTH-1:0] d,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] result,
    output logic                  error
);

    localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL,
        SQR,
        FIN
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] n_q, n_d;
    logic [WORD_WIDTH-1:0] base_q, base_d;
    logic [WORD_WIDTH-1:0] exp_q, exp_d;
    logic [WORD_WIDTH-1:0] acc_q, acc_d;
    logic [WORD_WIDTH-1:0] t_q, t_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [WORD_WIDTH-1:0] result_q, result_d;
    logic                  error_q, error_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // One interleaved multiplier step: t = 2t mod N, then t = t + a mod N when the b bit is set.
    logic [WORD_WIDTH-1:0] mul_a;
    logic                  mul_bit;
    logic [WORD_WIDTH:0]   n_ext;
    logic [WORD_WIDTH:0]   t_dbl;
    logic [WORD_WIDTH:0]   t_red1;
    logic [WORD_WIDTH:0]   t_add;
    logic [WORD_WIDTH-1:0] prod;

    always_comb begin
        mul_a   = (state_q == MUL) ? acc_q : base_q;
        mul_bit = base_q[LAST - cnt_q];
        n_ext   = {1'b0, n_q};
        t_dbl   = {t_q, 1'b0};
        t_red1  = (t_dbl >= n_ext) ? (t_dbl - n_ext) : t_dbl;
        t_add   = mul_bit ? (t_red1 + {1'b0, mul_a}) : t_red1;
        prod    = (t_add >= n_ext) ? WORD_WIDTH'(t_add - n_ext) : t_add[WORD_WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        base_d   = base_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        result_d = result_q;
        error_d  = error_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // The done cycle is spent in IDLE; a held start is taken on the cycle after it.
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    n_d      = N;
                    base_d   = msg_in;
                    exp_d    = mode ? d : e;
                    acc_d    = '0;
                    t_d      = '0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    result_d = '0;
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if ((n_q < WORD_WIDTH'(2)) || (base_q >= n_q)) begin
                    error_d  = 1'b1;
                    result_d = '0;
                    state_d  = FIN;
                end else begin
                    acc_d   = WORD_WIDTH'(1);
                    t_d     = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                t_d   = prod;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    t_d   = '0;
                    cnt_d = '0;
                    // Product always computed; only committed for a set exponent bit.
                    if (exp_q[idx_q]) begin
                        acc_d = prod;
                    end
                    state_d = SQR;
                end
            end
            SQR: begin
                t_d   = prod;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    t_d    = '0;
                    cnt_d  = '0;
                    base_d = prod;
                    idx_d  = idx_q + 1'b1;
                    state_d = (idx_q == LAST) ? FIN : MUL;
                end
            end
            FIN: begin
                result_d = error_q ? '0 : acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            t_q      <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            error_q  <= error_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign error  = error_q;

endmodule

// File: tb/tb_rsa_cipher.sv
// Self-checking bench for rsa_cipher at WORD_WIDTH=8: directed key cases plus randomized
// requests compared against a plain-arithmetic modular exponentiation model.
module tb_rsa_cipher;

    localparam int W = 8;
    localparam int LAT_OK = 2 + 2 * W * W;
    localparam int LAT_ERR = 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] msg_in;
    logic [W-1:0] N;
    logic [W-1:0] e;
    logic [W-1:0] d;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         error;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    rsa_cipher #(.WORD_WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .msg_in (msg_in),
        .N      (N),
        .e      (e),
        .d      (d),
        .busy   (busy),
        .done   (done),
        .result (result),
        .error  (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_count++;
    end

    task automatic check_val(input string tag, input longint got, input longint expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
        end
    endtask

    // msg^ex mod nn, right-to-left, with ordinary integer arithmetic
    function automatic longint model_pow(input longint msg, input longint ex, input longint nn);
        longint r = 1;
        longint b = msg % nn;
        longint x = ex;
        for (int i = 0; i < W; i++) begin
            if (x % 2 == 1) r = (r * b) % nn;
            b = (b * b) % nn;
            x = x / 2;
        end
        return r % nn;
    endfunction

    task automatic run_req(input string tag, input logic m, input logic [W-1:0] msg,
                           input logic [W-1:0] nn, input logic [W-1:0] ee,
                           input logic [W-1:0] dd, input int poke);
        longint exp_r;
        bit     exp_err;
        int     lat;
        int     cnt;
        int     d0;
        bit     busy_ok;
        exp_err = (nn < 2) || (msg >= nn);
        exp_r   = exp_err ? 0 : model_pow(longint'(msg), longint'(m ? dd : ee), longint'(nn));
        lat     = exp_err ? LAT_ERR : LAT_OK;
        @(negedge clk);
        mode = m; msg_in = msg; N = nn; e = ee; d = dd; start = 1'b1;
        d0 = done_count;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        mode   = 1'($urandom_range(1, 0));
        msg_in = W'($urandom_range(255, 0));
        N      = W'($urandom_range(255, 0));
        e      = W'($urandom_range(255, 0));
        d      = W'($urandom_range(255, 0));
        busy_ok = busy;
        cnt = 0;
        while (!done && cnt < 400) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (cnt == poke) begin
                start = 1'b1; msg_in = 5; mode = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        $display("txn %s mode=%0d msg=%0d N=%0d e=%0d d=%0d -> result=%0d err=%0d lat=%0d (exp %0d/%0d/%0d)",
                 tag, m, msg, nn, ee, dd, result, error, cnt, exp_r, exp_err, lat);
        check_val({tag, ".latency"}, cnt, lat);
        check_val({tag, ".result"}, longint'(result), exp_r);
        check_val({tag, ".error"}, longint'(error), longint'(exp_err));
        check_val({tag, ".busy_during"}, longint'(busy_ok), 1);
        @(posedge clk);
        @(negedge clk);
        check_val({tag, ".done_pulse"}, longint'(done), 0);
        check_val({tag, ".busy_after"}, longint'(busy), 0);
        check_val({tag, ".result_held"}, longint'(result), exp_r);
        check_val({tag, ".done_count"}, done_count - d0, 1);
    endtask

    initial begin
        int cnt;
        int first;
        int second;
        int gap_busy;
        int d0;
        logic [W-1:0] rn, rm;

        rst = 1'b0; start = 1'b0; mode = 1'b0;
        msg_in = '0; N = '0; e = '0; d = '0;
        #1;
        check_val("reset.busy", longint'(busy), 0);
        check_val("reset.done", longint'(done), 0);
        check_val("reset.result", longint'(result), 0);
        check_val("reset.error", longint'(error), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_req("encrypt", 1'b0, 8'd42, 8'd143, 8'd7, 8'd103, -1);
        run_req("decrypt", 1'b1, 8'd81, 8'd143, 8'd7, 8'd103, -1);
        run_req("msg_eq_n", 1'b0, 8'd143, 8'd143, 8'd7, 8'd103, -1);
        run_req("n_one", 1'b0, 8'd0, 8'd1, 8'd7, 8'd103, -1);
        run_req("msg_zero", 1'b0, 8'd0, 8'd143, 8'd7, 8'd103, -1);
        run_req("exp_zero", 1'b0, 8'd42, 8'd143, 8'd0, 8'd103, -1);
        run_req("busy_start", 1'b0, 8'd42, 8'd143, 8'd7, 8'd103, 20);

        // Abort mid-operation: outputs clear at once and the aborted run never completes.
        @(negedge clk);
        mode = 1'b0; msg_in = 8'd42; N = 8'd143; e = 8'd7; d = 8'd103; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b0;
        #1;
        $display("txn reset_mid busy=%0d done=%0d result=%0d err=%0d", busy, done, result, error);
        check_val("rstmid.busy", longint'(busy), 0);
        check_val("rstmid.done", longint'(done), 0);
        check_val("rstmid.result", longint'(result), 0);
        check_val("rstmid.error", longint'(error), 0);
        d0 = done_count;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        check_val("rstmid.no_done", done_count - d0, 0);
        run_req("after_reset", 1'b0, 8'd42, 8'd143, 8'd7, 8'd103, -1);

        // start held high across completion: second request begins the cycle after done.
        @(negedge clk);
        mode = 1'b0; msg_in = 8'd42; N = 8'd143; e = 8'd7; d = 8'd103; start = 1'b1;
        cnt = 0; first = -1; second = -1; gap_busy = -1;
        while (second < 0 && cnt < 600) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (first >= 0 && cnt == first + 1) gap_busy = busy;
            if (done) begin
                if (first < 0) first = cnt;
                else second = cnt;
            end
        end
        start = 1'b0;
        $display("txn back_to_back first=%0d second=%0d gap_busy=%0d result=%0d",
                 first, second, gap_busy, result);
        check_val("b2b.first", first, 1 + LAT_OK);
        check_val("b2b.second", second, 3 + 2 * LAT_OK);
        check_val("b2b.gap_busy", gap_busy, 0);
        check_val("b2b.result", longint'(result), 81);
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            rn = W'($urandom_range(255, 0));
            if ($urandom_range(5, 0) == 0 || rn == 0) rm = W'($urandom_range(255, 0));
            else rm = W'($urandom % rn);
            run_req($sformatf("rand%0d", i), 1'($urandom_range(1, 0)), rm, rn,
                    W'($urandom_range(255, 0)), W'($urandom_range(255, 0)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
